// File: rtl/karatsuba_op_sequencer.sv
// Valid/ready wrapper around the iterative Karatsuba multiplier. It owns the
// multiplier clear pulse and enable window, and captures C after LATENCY enabled cycles.
module karatsuba_op_sequencer #(
  parameter int N       = 32,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_z,
  output logic             busy,
  output logic             mul_rst,
  output logic             mul_enable,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_c
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   op_a, op_a_n;
  logic [N-1:0]   op_b, op_b_n;
  logic [2*N-1:0] z, z_n;
  logic           vld, vld_n;
  logic [CW-1:0]  cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      z     <= '0;
      vld   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      z     <= z_n;
      vld   <= vld_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    z_n     = z;
    vld_n   = vld;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        // abort is deliberately ignored here so a simultaneous request is taken
        if (in_valid) begin
          op_a_n  = in_a;
          op_b_n  = in_b;
          state_n = CLR;
        end
      end
      CLR: begin
        cnt_n   = '0;
        state_n = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == LAST) begin
          cnt_n   = '0;
          z_n     = mul_c;
          vld_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_n = 1'b0;
          if (in_valid) begin
            op_a_n  = in_a;
            op_b_n  = in_b;
            state_n = CLR;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
  assign busy       = (state == CLR) | (state == RUN);
  assign mul_rst    = rst | (state == CLR);
  assign mul_enable = (state == RUN);
  assign mul_a      = op_a;
  assign mul_b      = op_b;
  assign out_valid  = vld;
  assign out_z      = z;

endmodule

// File: tb/tb_karatsuba_op_sequencer.sv
// Scoreboard bench for karatsuba_op_sequencer with a behavioural multiplier whose
// C output is only correct after exactly LATENCY-1 enabled edges since its clear.
module tb_karatsuba_op_sequencer;
  localparam int N   = 32;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_a = '0;
  logic [N-1:0]   in_b = '0;
  logic           abort = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] out_z;
  logic           busy;
  logic           mul_rst;
  logic           mul_enable;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_c;

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;
  logic [2*N-1:0] exp_q[$];

  karatsuba_op_sequencer #(.N(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .busy(busy), .mul_rst(mul_rst),
    .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c)
  );

  always #5 clk = ~clk;

  // Multiplier model: wrong value unless sampled at the exact final RUN edge
  logic [7:0] mcnt;
  always @(posedge clk or posedge mul_rst) begin
    if (mul_rst) mcnt <= '0;
    else if (mul_enable) mcnt <= mcnt + 8'd1;
  end
  assign mul_c = (mcnt == 8'(LAT - 1)) ? (64'(mul_a) * 64'(mul_b))
                                       : ~(64'(mul_a) * 64'(mul_b));

  // Inputs change at posedge+2, so negedge sees the values the next edge will take
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready)
      exp_q.push_back(64'(in_a) * 64'(in_b));
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected: out_z=%h with no pending operation", out_z);
      end else begin
        logic [2*N-1:0] e;
        e = exp_q.pop_front();
        if (out_z !== e) begin
          n_miss++;
          $display("FAIL sb_result: out_z=%h expected %h", out_z, e);
        end
      end
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    @(posedge clk); #2;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_miss++;
      $display("FAIL run_op_timeout: no out_valid after %0d cycles", lat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, out_z, in_ready, busy, mul_rst, mul_enable} !== {1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_outputs: vld=%b z=%h rdy=%b busy=%b mrst=%b men=%b required 0 0 1 0 1 0",
               out_valid, out_z, in_ready, busy, mul_rst, mul_enable);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(posedge clk); #2;
    in_a = 32'd10; in_b = 32'd12; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      logic exp_rst, exp_en, exp_vld;
      @(negedge clk);
      exp_rst = (k == 1);
      exp_en  = (k >= 2 && k <= 5);
      exp_vld = (k == 6);
      n_vec++;
      if ({mul_rst, mul_enable, out_valid, busy} !== {exp_rst, exp_en, exp_vld, exp_rst | exp_en}) begin
        n_miss++;
        $display("FAIL single_cycle%0d: rst/en/vld/busy=%b%b%b%b required %b%b%b%b", k,
                 mul_rst, mul_enable, out_valid, busy, exp_rst, exp_en, exp_vld, exp_rst | exp_en);
      end
    end
    n_vec++;
    if (out_z !== 64'd120) begin
      n_miss++;
      $display("FAIL single_z: out_z=%0d required 120", out_z);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_max;
    int lat;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    n_vec++;
    if (out_z !== 64'hFFFFFFFE00000001 || lat != LAT + 2) begin
      n_miss++;
      $display("FAIL max_ff: out_z=%h lat=%0d required FFFFFFFE00000001 lat=%0d", out_z, lat, LAT + 2);
    end
    @(posedge clk); #2;
    run_op(32'hFFFFFFFF, 32'd255, lat);
    n_vec++;
    if (out_z !== 64'd1095216660225) begin
      n_miss++;
      $display("FAIL max_255: out_z=%0d required 1095216660225", out_z);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_op(32'd6, 32'd7, lat);
    in_a = 32'd99; in_b = 32'd99; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_z !== 64'd42 || in_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_hold%0d: vld=%b z=%0d rdy=%b required 1 42 0", k, out_valid, out_z, in_ready);
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL bp_release: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #2;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_after: vld=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    int i = 0;
    int cyc = 0;
    int last_acc = -1;
    int start_out = n_out;
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_a = 32'd0; in_b = 32'd12; in_valid = 1'b1;
    while (i < 10 && cyc < 200) begin
      logic acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (last_acc >= 0 && in_ready && !out_valid) begin
        n_vec++;
        n_miss++;
        $display("FAIL b2b_idle: idle bubble at cycle %0d", cyc);
      end
      if (acc) begin
        if (last_acc >= 0) begin
          n_vec++;
          if (cyc - last_acc != LAT + 2) begin
            n_miss++;
            $display("FAIL b2b_interval: %0d cycles between accepts required %0d", cyc - last_acc, LAT + 2);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #2;
      cyc++;
      if (acc) begin
        i++;
        if (i < 10) in_a = 32'(i);
        else in_valid = 1'b0;
      end
    end
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    @(posedge clk); #2;
    n_vec++;
    if (n_out - start_out != 10 || exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL b2b_count: %0d results, %0d pending required 10, 0", n_out - start_out, exp_q.size());
    end
  endtask

  task automatic test_abort;
    int lat;
    @(posedge clk); #2;
    in_a = 32'd100; in_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #2;   // accept edge; CLR follows
    in_valid = 1'b0;
    @(posedge clk); #2;   // RUN cycle 1
    @(posedge clk); #2;   // RUN cycle 2
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    void'(exp_q.pop_back());
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || mul_enable !== 1'b0 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_idle: busy=%b rdy=%b en=%b vld=%b required 0 1 0 0", busy, in_ready, mul_enable, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        n_vec++;
        n_miss++;
        $display("FAIL abort_no_result: out_valid=1 at cycle %0d required 0", k);
      end
    end
    run_op(32'd7, 32'd9, lat);
    n_vec++;
    if (out_z !== 64'd63) begin
      n_miss++;
      $display("FAIL abort_next: out_z=%0d required 63", out_z);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_async_reset;
    int lat;
    @(posedge clk); #2;
    in_a = 32'd11; in_b = 32'd13; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_z !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0 || mul_rst !== 1'b1) begin
      n_miss++;
      $display("FAIL arst_values: vld=%b z=%h rdy=%b busy=%b mrst=%b required 0 0 1 0 1",
               out_valid, out_z, in_ready, busy, mul_rst);
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    run_op(32'd3, 32'd5, lat);
    n_vec++;
    if (out_z !== 64'd15 || lat != LAT + 2) begin
      n_miss++;
      $display("FAIL arst_next: out_z=%0d lat=%0d required 15 lat=%0d", out_z, lat, LAT + 2);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover: %0d results never produced", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/karatsuba_op_sequencer.md
Name: karatsuba_op_sequencer

Overview:
Handshake front/back end for iterative_karatsuba_32_16. It accepts operand pairs over a valid/ready interface and generates the multiplier's clear pulse and enable window. It captures the product after a fixed iteration count and presents it downstream over a second valid/ready interface. The testbench and system logic talk to this block, never directly to the multiplier's rst/enable pins.

Parameters:
N, 32, operand width; product width is 2*N
LATENCY, 4, multiplier cycles from enable rise to a valid C; minimum 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands
in_a  input  N  operand A
in_b  input  N  operand B
abort  input  1  synchronous cancel of an in-flight operation
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_z  output  2*N  product
busy  output  1  high in CLR or RUN
mul_rst  output  1  to multiplier rst
mul_enable  output  1  to multiplier enable
mul_a  output  N  to multiplier A
mul_b  output  N  to multiplier B
mul_c  input  2*N  from multiplier C

Behaviour:
- Reset: asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, op_a/op_b=0, out_z=0, out_valid=0, iteration counter=0.
- mul_rst is driven high while rst is high.
- States: IDLE, CLR, RUN, DONE. All outputs are decoded from registered state and registers only; no input-to-output combinational path except in_ready, which depends on out_ready.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a/in_b into op_a/op_b, then go to CLR.
- CLR:
  - Lasts exactly one cycle.
  - mul_rst=1, mul_enable=0.
  - Clears the counter; next state is RUN.
- RUN:
  - mul_enable=1, mul_rst=0.
  - Counter increments each cycle.
  - At the edge where counter==LATENCY-1: capture mul_c into out_z, set out_valid, go to DONE.
  - RUN lasts exactly LATENCY cycles.
- DONE:
  - out_valid=1, mul_enable=0.
  - out_z is held stable until the handshake completes.
  - On out_ready: clear out_valid.
  - If in_valid is also high in the same cycle, latch the new operands and go to CLR (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- mul_a/mul_b = op_a/op_b in every state. They are stable throughout CLR and RUN.
- busy = (state==CLR) | (state==RUN).
- Latency: from the accept edge to out_valid high is LATENCY+1 cycles (1 CLR + LATENCY RUN).
- abort:
  - In CLR or RUN: go to IDLE next edge; no result is produced; out_valid stays 0; mul_enable drops.
  - In IDLE: ignored.
  - In DONE: ignored; a pending result is never discarded.
  - abort and in_valid together in IDLE: the operands are accepted.
- Product width: out_z is 2*N bits exactly as delivered on mul_c; no truncation or extension.
- Async reset mid-RUN: the block returns immediately to the reset values; the next operation starts cleanly with a CLR cycle.
- mul_c is sampled only at the final RUN edge; values at any other time are ignored.

Test Plan:
- Single op: after reset, in_a=10, in_b=12, in_valid for 1 cycle → mul_rst is high for 1 cycle, then mul_enable is high for 4 cycles; out_valid rises 5 cycles after the accept edge with out_z=120.
- Max operands: in_a=in_b=32'hFFFFFFFF → out_z=64'hFFFFFFFE00000001. Also 4294967295*255 → 1095216660225.
- Backpressure: hold out_ready=0 for 20 cycles after the result appears → out_valid and out_z are stable and in_ready=0 throughout; assert out_ready → in_ready=1 in the same cycle.
- Back-to-back: sweep in_a=0..9 with in_b=12, in_valid continuously high and out_ready=1 → 10 results equal to i*12 in order, one new op accepted every 6 cycles, no IDLE cycles between ops.
- Abort: assert abort in RUN cycle 2 → IDLE next cycle, no out_valid. Next op 7*9 → out_z=63.
- Async reset mid-RUN: pulse rst between clock edges → out_valid=0, out_z=0, and in_ready=1 immediately. A subsequent op 3*5 → out_z=15 with normal latency.
